// File: rtl/pair_adder_stage.sv
// Pairs consecutive valid operand words (A then B) and emits a registered
// WIDTH-bit sum with carry, a one-cycle valid strobe, a pair counter and a sticky carry flag.
module pair_adder_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             op_pending,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    output logic [CNT_W-1:0] pair_count,
    output logic             carry_seen,
    output logic             dbg_state_o
);

    // Handshake: in_valid has no back-pressure; every cycle with in_valid=1
    // (and no rst/flush) consumes in_data, and out_valid is a one-cycle
    // strobe with no ready, so the consumer must sample it when it is high.
    typedef enum logic {
        S_A = 1'b0,
        S_B = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   pair_count_q;
    logic               carry_seen_q;
    logic [WIDTH:0]     sum_full_d;

    // Only consumed when in_valid=1, so an undriven in_data never reaches state.
    always_comb begin
        sum_full_d = {1'b0, op_a_q} + {1'b0, in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_A;
            op_a_q       <= '0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            pair_count_q <= '0;
            carry_seen_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (flush) begin
                state_q <= S_A;
                op_a_q  <= '0;
            end else begin
                case (state_q)
                    S_A: begin
                        if (in_valid) begin
                            op_a_q  <= in_data;
                            state_q <= S_B;
                        end
                    end
                    S_B: begin
                        if (in_valid) begin
                            sum_q        <= sum_full_d[WIDTH-1:0];
                            cout_q       <= sum_full_d[WIDTH];
                            out_valid_q  <= 1'b1;
                            pair_count_q <= pair_count_q + CNT_W'(1);
                            carry_seen_q <= carry_seen_q | sum_full_d[WIDTH];
                            state_q      <= S_A;
                        end
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    assign op_pending  = (state_q == S_B);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign out_valid   = out_valid_q;
    assign pair_count  = pair_count_q;
    assign carry_seen  = carry_seen_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pair_adder_stage.sv
// Directed bench for pair_adder_stage: inputs change on the falling edge,
// outputs are checked 1 ns after each rising edge against hand-computed values.
module tb_pair_adder_stage;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             op_pending;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;
    logic [CNT_W-1:0] pair_count;
    logic             carry_seen;
    logic             dbg_state_o;

    int n_vec = 0;
    int n_err = 0;

    pair_adder_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .op_pending (op_pending),
        .sum        (sum),
        .cout       (cout),
        .out_valid  (out_valid),
        .pair_count (pair_count),
        .carry_seen (carry_seen),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs on the falling edge, then settle past the rising edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic f, input logic r);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        flush    = f;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [WIDTH-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 'x, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input logic [WIDTH-1:0] s,
                             input logic c, input logic [CNT_W-1:0] pc);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"}, 32'(sum), 32'(s));
        chk({tag, ".cout"}, 32'(cout), 32'(c));
        chk({tag, ".pair_count"}, 32'(pair_count), 32'(pc));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".sum"}, 32'(sum), 32'd0);
        chk({tag, ".cout"}, 32'(cout), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".op_pending"}, 32'(op_pending), 32'd0);
        chk({tag, ".pair_count"}, 32'(pair_count), 32'd0);
        chk({tag, ".carry_seen"}, 32'(carry_seen), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;

        // Reset for two cycles
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk_cleared("reset");

        // Basic pair 3 + 5
        word(4'd3);
        chk("basic.a.op_pending", 32'(op_pending), 32'd1);
        chk("basic.a.out_valid", 32'(out_valid), 32'd0);
        word(4'd5);
        chk_pulse("basic", 4'd8, 1'b0, 8'd1);
        chk("basic.carry_seen", 32'(carry_seen), 32'd0);
        chk("basic.op_pending", 32'(op_pending), 32'd0);
        idle();
        chk("basic.one_pulse", 32'(out_valid), 32'd0);
        chk("basic.sum_hold", 32'(sum), 32'd8);

        // Carry pair 15 + 1, then 2 + 2 keeps carry_seen
        word(4'd15);
        word(4'd1);
        chk_pulse("carry", 4'd0, 1'b1, 8'd2);
        chk("carry.carry_seen", 32'(carry_seen), 32'd1);
        word(4'd2);
        word(4'd2);
        chk_pulse("carry2", 4'd4, 1'b0, 8'd3);
        chk("carry2.carry_seen", 32'(carry_seen), 32'd1);

        // Generator stream 0..15: pulses on every second word only
        for (int i = 0; i < 16; i++) begin
            word(4'(i));
            if (i % 2 == 1) begin
                chk_pulse("stream", 4'((2 * i - 1) % 16), 1'((2 * i - 1) >= 16),
                          8'(3 + (i + 1) / 2));
            end else begin
                chk("stream.no_pulse", 32'(out_valid), 32'd0);
            end
        end
        chk("stream.pair_count", 32'(pair_count), 32'd11);

        // Gap: A=7, three idle cycles with undriven data, B=2
        word(4'd7);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("gap.op_pending", 32'(op_pending), 32'd1);
            chk("gap.out_valid", 32'(out_valid), 32'd0);
        end
        word(4'd2);
        chk_pulse("gap", 4'd9, 1'b0, 8'd12);

        // Flush discards A=9; the word presented with flush is ignored
        word(4'd9);
        step(1'b1, 4'd4, 1'b1, 1'b0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.op_pending", 32'(op_pending), 32'd0);
        chk("flush.pair_count", 32'(pair_count), 32'd12);
        chk("flush.sum_hold", 32'(sum), 32'd9);
        chk("flush.carry_hold", 32'(carry_seen), 32'd1);
        word(4'd4);
        chk("flush.a.out_valid", 32'(out_valid), 32'd0);
        word(4'd4);
        chk_pulse("flush", 4'd8, 1'b0, 8'd13);

        // Reset while A=6 is pending
        word(4'd6);
        step(1'b0, 'x, 1'b0, 1'b1);
        chk_cleared("midrst");
        word(4'd1);
        word(4'd2);
        chk_pulse("midrst", 4'd3, 1'b0, 8'd1);
        chk("midrst.carry_seen", 32'(carry_seen), 32'd0);

        // Counter wrap: 254 more pairs reach 255, the next wraps to 0
        for (int i = 0; i < 254; i++) begin
            word(4'd1);
            word(4'd1);
        end
        chk("wrap.pair_count_255", 32'(pair_count), 32'd255);
        word(4'd1);
        word(4'd1);
        chk_pulse("wrap", 4'd2, 1'b0, 8'd0);

        // rst together with flush and in_valid behaves as reset
        word(4'd1);
        word(4'd1);
        chk("rstflush.pre_count", 32'(pair_count), 32'd1);
        word(4'd8);
        step(1'b1, 4'd8, 1'b1, 1'b1);
        chk_cleared("rstflush");
        word(4'd8);
        word(4'd9);
        chk_pulse("rstflush", 4'd1, 1'b1, 8'd1);
        chk("rstflush.carry_seen", 32'(carry_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
